// File: rtl/unified_bus_arbiter.sv
// rtl/unified_bus_arbiter.sv - shares one memory bus between fetch (I) and load/store (D) requesters
// Round-robin on ties, per-transaction watchdog turns a hung bus into an error response.
module unified_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                d_err,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall
);

  localparam int SW = DATA_W / 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS_I = 2'd1;
  localparam logic [1:0] S_BUS_D = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  // Last wait cycle allowed: the counter would reach TIMEOUT on this cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]     mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              if_err_q, if_err_d;
  logic              d_err_q, d_err_d;
  logic              grant_d;
  logic              owner_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
    grant_d     = 1'b0;
    owner_d     = (state_q == S_BUS_D);
    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          // On a tie, the requester that did not own the bus last wins.
          grant_d     = d_req && (!if_req || !last_d_q);
          mem_valid_d = 1'b1;
          cnt_d       = '0;
          if (grant_d) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wstrb_d = d_we ? d_wstrb : '0;
            state_d     = S_BUS_D;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
            state_d     = S_BUS_I;
          end
        end
      end
      S_BUS_I, S_BUS_D: begin
        if (mem_valid_q && mem_ready) begin
          mem_valid_d = 1'b0;
          cnt_d       = '0;
          last_d_d    = owner_d;
          state_d     = S_RESP;
          if (owner_d) begin
            d_done_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          mem_valid_d = 1'b0;
          cnt_d       = '0;
          last_d_d    = owner_d;
          state_d     = S_RESP;
          if (owner_d) begin
            d_done_d  = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_done_d  = 1'b1;
            if_err_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_err_q    <= if_err_d;
      d_err_q     <= d_err_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_err    = if_err_q;
  assign d_err     = d_err_q;
  assign stall     = (if_req & ~if_done_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_unified_bus_arbiter.sv
// tb/tb_unified_bus_arbiter.sv - scoreboard bench for unified_bus_arbiter
module tb_unified_bus_arbiter;

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rdata;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done, if_err;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_done, d_err;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;

  done_t       exp_q[$];
  bus_t        bus_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          resp_delay = 0;
  bit          resp_en = 1'b1;
  int          wait_cnt;
  logic [31:0] mdl_i = '0;
  logic [31:0] mdl_d = '0;
  int          vcnt;

  unified_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [31:0] a, input logic [31:0] rd, input bit err);
    bus_t  b;
    done_t e;
    if_req = 1'b1;
    if_addr = a;
    b.addr = a; b.we = 1'b0; b.wdata = '0; b.wstrb = '0; b.rdata = rd;
    bus_q.push_back(b);
    mdl_i = err ? 32'h0 : rd;
    e.is_d = 1'b0; e.err = err; e.rdata = mdl_i;
    exp_q.push_back(e);
  endtask

  task automatic start_d(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] rd, input bit err);
    bus_t  b;
    done_t e;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws;
    b.addr = a; b.we = we; b.wdata = wd; b.wstrb = we ? ws : 4'h0; b.rdata = rd;
    bus_q.push_back(b);
    if (err) mdl_d = 32'h0;
    else if (!we) mdl_d = rd;
    e.is_d = 1'b1; e.err = err; e.rdata = mdl_d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int max);
    for (int c = 0; c < max; c++) begin
      tick();
      if (if_done) if_req = 1'b0;
      if (d_done) d_req = 1'b0;
      if (!if_req && !d_req && exp_q.size() == 0) return;
    end
    check("drain_timeout", 0, 1);
  endtask

  // Memory model: answers the front bus item after resp_delay wait cycles.
  initial begin : responder
    bus_t b;
    mem_ready = 1'b0; mem_rdata = '0; wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        mem_ready = 1'b0; wait_cnt = 0;
      end else if (mem_ready || (wait_cnt > 0 && !mem_valid)) begin
        if (bus_q.size() > 0) void'(bus_q.pop_front());
        mem_ready = 1'b0; wait_cnt = 0;
      end else if (mem_valid) begin
        wait_cnt++;
        if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
        else begin
          b = bus_q[0];
          check("mem_addr", mem_addr, b.addr);
          check("mem_we", mem_we, b.we);
          check("mem_wstrb", mem_wstrb, b.wstrb);
          if (b.we) check("mem_wdata", mem_wdata, b.wdata);
          if (resp_en && wait_cnt > resp_delay) begin
            mem_ready = 1'b1; mem_rdata = b.rdata;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    done_t e;
    if (reset) begin
      if (if_done && d_done) check("both_done", 1, 0);
      if (if_done || d_done) begin
        if (exp_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("done_owner", d_done, e.is_d);
          check("done_err", e.is_d ? d_err : if_err, e.err);
          check("done_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0;
    tick(); tick();
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_done", {if_done, d_done, if_err, d_err}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    check("rst_stall", stall, 0);
    reset = 1'b1;
    tick();

    // Tie right after reset goes to D, then I; next tie (last_owner = I) goes to D again.
    for (int k = 0; k < 2; k++) begin
      start_d(1'b0, 32'h300 + k, 32'h0, 4'h0, 32'h1111_0000 + k, 1'b0);
      start_fetch(32'h40 + k, 32'h2222_0000 + k, 1'b0);
      drain(30);
    end

    // Fetch with minimum latency and cycle-exact stall.
    tick();
    start_fetch(32'h10, 32'h0050_0093, 1'b0);
    #1 check("fetch_stall_c0", stall, 1);
    tick();
    check("fetch_valid_c1", mem_valid, 1);
    check("fetch_stall_c1", stall, 1);
    tick();
    check("fetch_done_c2", if_done, 1);
    check("fetch_stall_c2", stall, 0);
    check("fetch_valid_c2", mem_valid, 0);
    if_req = 1'b0;
    tick();

    // Load, then store with 3 wait states: d_rdata keeps the loaded word.
    start_d(1'b0, 32'h200, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0);
    drain(20);
    resp_delay = 3;
    start_d(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 1'b0);
    drain(20);
    check("store_d_rdata", d_rdata, 32'hCAFE_0001);
    resp_delay = 0;

    // Watchdog: 4 wait cycles then error; next fetch proceeds normally.
    resp_en = 1'b0;
    start_fetch(32'h20, 32'h5555_5555, 1'b1);
    vcnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_valid) vcnt++;
      if (if_done) break;
    end
    check("to_valid_cycles", vcnt, 4);
    check("to_if_done", if_done, 1);
    check("to_if_rdata", if_rdata, 0);
    if_req = 1'b0;
    tick();
    resp_en = 1'b1;
    start_fetch(32'h24, 32'h0000_0013, 1'b0);
    drain(20);

    // Requester withdraws after grant; transfer still completes.
    resp_delay = 2;
    start_fetch(32'h80, 32'hABCD_0080, 1'b0);
    tick();
    check("wd_valid", mem_valid, 1);
    if_req = 1'b0;
    drain(20);
    tick();
    check("wd_idle_valid", mem_valid, 0);
    check("wd_stall", stall, 0);
    resp_delay = 0;

    // Reset mid-transaction in BUS_D, after a completed load left last_owner = D.
    start_d(1'b0, 32'h210, 32'h0, 4'h0, 32'h7777_0000, 1'b0);
    drain(20);
    resp_en = 1'b0;
    start_d(1'b0, 32'h400, 32'h0, 4'h0, 32'hAAAA_AAAA, 1'b0);
    tick();
    tick();
    check("mid_valid_pre", mem_valid, 1);
    #2 reset = 1'b0;
    d_req = 1'b0;
    exp_q.delete();
    bus_q.delete();
    mdl_d = '0; mdl_i = '0;
    #1 check("mid_valid_async", mem_valid, 0);
    check("mid_d_done", d_done, 0);
    tick();
    check("mid_d_rdata", d_rdata, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    resp_en = 1'b1;
    tick();
    start_d(1'b0, 32'h500, 32'h0, 4'h0, 32'h3333_0000, 1'b0);
    start_fetch(32'h90, 32'h4444_0000, 1'b0);
    drain(30);

    tick();
    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    check("bus_q_empty", bus_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

endmodule
